// File: rtl/fp_addsub_pkg.sv
// Shared types and constants for the single-precision add/sub issue path.
// Optional statistics counters in fp_operand_issue: FP_OPERAND_ISSUE_STATS_EN.
package fp_addsub_pkg;

    localparam int          FP_W       = 32;
    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } fp_class_e;

    typedef struct packed {
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
        logic            bypass;
        logic [FP_W-1:0] bypass_result;
    } fp_entry_t;

    // Denormals (exponent 0) classify as ZERO so they are flushed downstream.
    function automatic fp_class_e fp_classify(input logic [FP_W-1:0] x);
        fp_class_e cls;
        if (x[30:23] == 8'h00)
            cls = ZERO;
        else if (x[30:23] != FP_EXP_MAX)
            cls = NORM;
        else if (x[22:0] == 23'h0)
            cls = INF;
        else
            cls = NAN;
        return cls;
    endfunction

endpackage

// File: rtl/fp_special_detect.sv
// Combinational special-operand detection: decides whether the add/sub
// datapath can be skipped and, if so, what the result is.
module fp_special_detect
    import fp_addsub_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] eb,
    output logic            bypass,
    output logic [FP_W-1:0] bypass_result
);

    fp_class_e cls_a;
    fp_class_e cls_b;

    // Priority-ordered special-case resolution.
    always_comb begin
        cls_a         = fp_classify(a);
        cls_b         = fp_classify(eb);
        bypass        = 1'b1;
        bypass_result = '0;
        if (cls_a == NAN || cls_b == NAN) begin
            bypass_result = FP_QNAN;
        end else if (cls_a == INF && cls_b == INF && (a[31] != eb[31])) begin
            bypass_result = FP_QNAN;
        end else if (cls_a == INF) begin
            bypass_result = a;
        end else if (cls_b == INF) begin
            bypass_result = eb;
        end else if (cls_a == ZERO && cls_b == ZERO) begin
            bypass_result = {a[31] & eb[31], 31'h0};
        end else if (cls_a == ZERO) begin
            bypass_result = {eb[31:23], (eb[30:23] != 8'h00) ? eb[22:0] : 23'h0};
        end else if (cls_b == ZERO) begin
            bypass_result = {a[31:23], (a[30:23] != 8'h00) ? a[22:0] : 23'h0};
        end else begin
            bypass = 1'b0;
        end
    end

endmodule

// File: rtl/fp_operand_issue.sv
// Issue stage for the single-precision add/sub datapath: handshake intake,
// subtraction folded into b's sign, special-case bypass, small FIFO and
// registered operand outputs.
// Optional feature macro: FP_OPERAND_ISSUE_STATS_EN (pop/bypass counters).
module fp_operand_issue
    import fp_addsub_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] in_a,
    input  logic [FP_W-1:0] in_b,
    input  logic            in_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] datain_a,
    output logic [FP_W-1:0] datain_b,
    output logic            out_bypass,
    output logic [FP_W-1:0] out_bypass_result
`ifdef FP_OPERAND_ISSUE_STATS_EN
    ,
    output logic [31:0]     stat_issued,
    output logic [31:0]     stat_bypassed
`endif
);

    fp_entry_t        mem [DEPTH];
    fp_entry_t        new_entry;
    fp_entry_t        head_q;
    fp_entry_t        head_next;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   remain;
    logic [PTR_W:0]   count_next;
    logic [FP_W-1:0]  eb;
    logic             full;
    logic             push_en;
    logic             pop_en;
    logic             spec_bypass;
    logic [FP_W-1:0]  spec_result;

    assign eb        = {in_b[31] ^ in_op, in_b[30:0]};
    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign in_ready  = !full;
    assign out_valid = (count != '0);
    assign push_en   = in_valid && in_ready && !flush;
    assign pop_en    = out_valid && out_ready && !flush;

    fp_special_detect u_detect (
        .a             (in_a),
        .eb            (eb),
        .bypass        (spec_bypass),
        .bypass_result (spec_result)
    );

    // Assemble the entry captured on push.
    always_comb begin
        new_entry               = '0;
        new_entry.a             = in_a;
        new_entry.b             = eb;
        new_entry.bypass        = spec_bypass;
        new_entry.bypass_result = spec_result;
    end

    // Next head: the pushed entry when it lands in an otherwise empty FIFO,
    // else whatever already sits at the advanced read pointer.
    always_comb begin
        rd_next    = rd_ptr + PTR_W'(pop_en);
        remain     = count - (PTR_W+1)'(pop_en);
        count_next = remain + (PTR_W+1)'(push_en);
        head_next  = (remain == '0) ? new_entry : mem[rd_next];
    end

    // Entry storage; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (push_en)
            mem[wr_ptr] <= new_entry;
    end

    // Pointers, occupancy and the registered head seen by the datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head_q <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en)
                wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr <= rd_next;
            count  <= count_next;
            if (count_next != '0)
                head_q <= head_next;
        end
    end

    assign datain_a          = head_q.a;
    assign datain_b          = head_q.b;
    assign out_bypass        = head_q.bypass;
    assign out_bypass_result = head_q.bypass_result;

`ifdef FP_OPERAND_ISSUE_STATS_EN
    // Issue statistics; cleared by reset only, wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued   <= '0;
            stat_bypassed <= '0;
        end else if (pop_en) begin
            stat_issued <= stat_issued + 32'd1;
            if (head_q.bypass)
                stat_bypassed <= stat_bypassed + 32'd1;
        end
    end
`endif

endmodule
